wptr_full_lvl: RTL
==================

// Module: wptr_full_lvl
// PURPOSE
//  Write-domain pointer/flag controller for the async FIFO, successor to the basic write-pointer/full block.
//  - Keeps the binary and Gray write pointers, the memory write address and a registered full flag.
//  - Adds a write-side fill level, a programmable almost-full flag and a sticky overflow error.
//  - Sits in the w_clk domain between the write client, the dual-port RAM and the rptr->wclk 2-FF synchroniser.
// PARAMETERS
//  ADDRSIZE   4  address width; depth DEPTH = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits
//  OVF_CNT_W  8  width of the optional saturating overflow counter
// PORTS
//  w_clk           in   1           write-domain clock
//  w_rst           in   1           asynchronous, active-high reset
//  w_en            in   1           write request
//  wq2_rptr        in   ADDRSIZE+1  Gray read pointer, already synchronised to w_clk
//  w_afull_thresh  in   ADDRSIZE+1  almost-full threshold, in entries (0..DEPTH)
//  w_ovf_clr       in   1           clears w_ovf (and the counter, when built)
//  w_addr          out  ADDRSIZE    RAM write address
//  w_gray_ptr      out  ADDRSIZE+1  registered Gray write pointer, to the wclk->rclk synchroniser
//  w_full          out  1           FIFO full (registered)
//  w_afull         out  1           level >= w_afull_thresh (registered)
//  w_level         out  ADDRSIZE+1  entries held, as seen from the write side (registered)
//  w_ovf           out  1           sticky: a write was attempted while full
//  w_ovf_cnt       out  OVF_CNT_W   dropped-write count (only with WPTR_OVF_CNT_EN)
// BEHAVIOUR
//  Reset (async assert, released on a w_clk edge): w_bin=0, w_gray_ptr=0, w_addr=0, w_full=0, w_afull=0,
//    w_level=0, w_ovf=0, w_ovf_cnt=0. Reset mid-operation drops all state. No RAM clear is needed.
//  Write accept: inc = w_en & ~w_full.
//    - w_bin_next = w_bin + inc, computed modulo 2**(ADDRSIZE+1), with natural wrap.
//    - w_gray_next = (w_bin_next>>1) ^ w_bin_next.
//    - Both pointers register on the next w_clk. w_addr = w_bin[ADDRSIZE-1:0] (comb from the register).
//    - Timing: the RAM write occurs at w_addr in the cycle inc=1; the pointer advances at the next edge.
//  Full: w_full <= (w_gray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
//    - Asserts on the edge that accepts the DEPTH-th outstanding entry.
//    - Deasserts one cycle after the synchronised rptr advances.
//  Level: r_bin = gray2bin(wq2_rptr) (XOR-prefix from the MSB, combinational).
//    - lvl_next = w_bin_next - r_bin, mod 2**(ADDRSIZE+1); the range is 0..DEPTH.
//    - Registers: w_level <= lvl_next; w_afull <= (lvl_next >= w_afull_thresh).
//    - w_afull_thresh=0 gives w_afull=1 after the first clock out of reset. Any threshold > DEPTH never asserts.
//    - The level is pessimistic (read pointer lags by 2 sync cycles): it never under-reports occupancy.
//  Invariant: w_full==1 iff w_level==DEPTH (both derived from the same next-state values).
//  Overflow: drop = w_en & w_full; a dropped write never moves the pointers or writes the RAM.
//    - w_ovf <= 1 on drop; it is held until w_ovf_clr.
//    - drop and w_ovf_clr in the same cycle: set wins (w_ovf stays 1).
//  Simultaneous accept on the last slot and an rptr advance: the full compare uses the current wq2_rptr only.
//    The flags stay consistent because both use the same next-state values.
// CONFIGURATION
//  Macro: WPTR_OVF_CNT_EN.
//  - Defined: w_ovf_cnt increments by 1 on each drop and saturates at 2**OVF_CNT_W-1.
//    w_ovf_clr zeroes it; with drop and clr in the same cycle the counter loads 1.
//  - Undefined: the w_ovf_cnt port and its logic are absent; all other behaviour is identical.
// TESTING (ADDRSIZE=2, DEPTH=4, wq2_rptr held 0 unless stated)
//  1 Reset: w_rst=1 with w_en=1 toggling -> all outputs 0. Release and write 1 -> w_addr=1, w_gray_ptr=3'b001, w_level=1.
//  2 Fill: 4 consecutive w_en -> w_full=1 and w_level=4 after the 4th edge; w_gray_ptr=3'b110; w_addr wraps to 0.
//  3 Overflow: with full, a 5th w_en -> pointers unchanged, w_ovf=1 (w_ovf_cnt=1 if built).
//    A later w_ovf_clr coincident with a drop -> w_ovf stays 1, counter=1.
//  4 Drain/wrap: from full, step wq2_rptr Gray 000->001->011 -> w_full=0 next cycle, w_level 4->3->2.
//    Then write 8 more entries with a tracking reader -> the pointer wraps 111->000 with no false full.
//  5 Almost-full: thresh=3 -> w_afull rises on the edge where w_level becomes 3.
//    thresh=0 -> w_afull=1 after the first clock; thresh=5 -> never asserts.
//  6 Counter saturation (macro on, OVF_CNT_W=2): 5 drops -> w_ovf_cnt=3.
//    Macro off: the design elaborates without w_ovf_cnt and tests 1-5 still pass.

Source files
------------

// File: rtl/wptr_full_lvl.sv
`default_nettype none
// ============================================================================
//  Module   : wptr_full_lvl
//  Purpose  : Write-domain pointer and flag controller for an async FIFO.
//             Keeps the binary and Gray write pointers and the RAM write
//             address. Registers full, write-side fill level and almost-full.
//             Holds a sticky overflow flag for writes attempted while full.
//  Ports    : w_clk / w_rst     write clock, async active-high reset
//             w_en              write request
//             wq2_rptr          Gray read pointer synchronised to w_clk
//             w_afull_thresh    almost-full threshold in entries (0..DEPTH)
//             w_ovf_clr         clears the overflow flag and counter
//             w_addr            RAM write address
//             w_gray_ptr        registered Gray write pointer
//             w_full, w_afull   registered full / almost-full flags
//             w_level           registered fill level (write-side view)
//             w_ovf             sticky overflow flag
//             w_ovf_cnt         saturating dropped-write count
//                               (present only with WPTR_OVF_CNT_EN defined)
//  Options  : `define WPTR_OVF_CNT_EN builds the overflow counter and port.
//  Revision : 1.0  initial release
// ============================================================================
module wptr_full_lvl #(
  parameter int ADDRSIZE  = 4,
  parameter int OVF_CNT_W = 8
) (
  input  logic                w_clk,
  input  logic                w_rst,
  input  logic                w_en,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   w_afull_thresh,
  input  logic                w_ovf_clr,
  output logic [ADDRSIZE-1:0] w_addr,
  output logic [ADDRSIZE:0]   w_gray_ptr,
  output logic                w_full,
  output logic                w_afull,
  output logic [ADDRSIZE:0]   w_level,
  output logic                w_ovf
`ifdef WPTR_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] w_ovf_cnt
`endif
);

  logic [ADDRSIZE:0] r_bin;
  logic [ADDRSIZE:0] r_gray;
  logic [ADDRSIZE:0] r_level;
  logic              r_full;
  logic              r_afull;
  logic              r_ovf;

  logic              w_inc;
  logic              w_drop;
  logic [ADDRSIZE:0] w_bin_next;
  logic [ADDRSIZE:0] w_gray_next;
  logic [ADDRSIZE:0] w_rbin;
  logic [ADDRSIZE:0] w_lvl_next;
  logic [ADDRSIZE:0] w_full_gray;

  assign w_inc       = w_en & ~r_full;
  assign w_drop      = w_en &  r_full;
  assign w_bin_next  = r_bin + {{ADDRSIZE{1'b0}}, w_inc};
  assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      w_rbin[i] = ^(wq2_rptr >> i);
    end
  end

  // Level and full share the same next-state pointer, so full==1 exactly
  // when the level equals DEPTH. The synchronised read pointer lags, so the
  // level can only over-report occupancy.
  assign w_lvl_next  = w_bin_next - w_rbin;
  assign w_full_gray = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
    end else begin
      r_bin   <= w_bin_next;
      r_gray  <= w_gray_next;
      r_level <= w_lvl_next;
      r_full  <= (w_gray_next == w_full_gray);
      r_afull <= (w_lvl_next >= w_afull_thresh);
    end
  end

  // A drop takes priority over a coincident clear so no event is lost.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef WPTR_OVF_CNT_EN
  localparam logic [OVF_CNT_W-1:0] c_cnt_max = '1;
  localparam logic [OVF_CNT_W-1:0] c_cnt_one = {{(OVF_CNT_W-1){1'b0}}, 1'b1};

  logic [OVF_CNT_W-1:0] r_ovf_cnt;

  // Drop with clear restarts the count at the current drop.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_ovf_cnt <= '0;
    end else if (w_drop) begin
      if (w_ovf_clr) begin
        r_ovf_cnt <= c_cnt_one;
      end else if (r_ovf_cnt != c_cnt_max) begin
        r_ovf_cnt <= r_ovf_cnt + c_cnt_one;
      end
    end else if (w_ovf_clr) begin
      r_ovf_cnt <= '0;
    end
  end

  assign w_ovf_cnt = r_ovf_cnt;
`endif

  assign w_addr     = r_bin[ADDRSIZE-1:0];
  assign w_gray_ptr = r_gray;
  assign w_full     = r_full;
  assign w_afull    = r_afull;
  assign w_level    = r_level;
  assign w_ovf      = r_ovf;

endmodule
`default_nettype wire
